// File: rtl/dmem_byte_streamer_if.sv
// Bus bundle for dmem_byte_streamer: request/status, memory read port and byte stream.
// The master modport is the streamer's view of the bundle.
interface dmem_byte_streamer_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic [31:0]      base_addr;
    logic [LEN_W-1:0] len;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_rdata;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;

    modport master (
        input  start, base_addr, len, mem_rdata, out_ready,
        output mem_addr, out_data, out_valid, busy, done
    );

    modport slave (
        output start, base_addr, len, mem_rdata, out_ready,
        input  mem_addr, out_data, out_valid, busy, done
    );
endinterface

// File: rtl/dmem_byte_streamer.sv
// Reads len bytes from data RAM starting at an arbitrary byte address and streams
// them little-endian, one byte per valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | word address on the memory port, word captured at the edge
// SEND  | presenting buffered bytes to the consumer
// DONE  | one-cycle completion pulse
module dmem_byte_streamer #(
    parameter int MEM_WORDS = 1024,
    parameter int LEN_W     = 16
) (
    input logic                    clk,
    input logic                    reset,
    dmem_byte_streamer_if.master   bus
);
    localparam int ADDR_W = $clog2(MEM_WORDS * 4);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [LEN_W-1:0]  rem, rem_nxt;
    logic [31:0]       wbuf, wbuf_nxt;

    // Address bits above the RAM size are dropped, giving the modulo wrap for free.
    logic unused_base_hi;
    assign unused_base_hi = ^bus.base_addr[31:ADDR_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            rem   <= '0;
            wbuf  <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            rem   <= rem_nxt;
            wbuf  <= wbuf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        rem_nxt   = rem;
        wbuf_nxt  = wbuf;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len != '0) begin
                        ptr_nxt   = bus.base_addr[ADDR_W-1:0];
                        rem_nxt   = bus.len;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            FETCH: begin
                wbuf_nxt  = bus.mem_rdata;
                state_nxt = SEND;
            end
            SEND: begin
                if (bus.out_ready) begin
                    rem_nxt = rem - 1'b1;
                    ptr_nxt = ptr + 1'b1;
                    if (rem == LEN_W'(1))
                        state_nxt = DONE;
                    else if (ptr[1:0] == 2'd3)
                        state_nxt = FETCH;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The pointer's low two bits double as the byte index within the buffered word.
    assign bus.mem_addr  = {{(32-ADDR_W){1'b0}}, ptr[ADDR_W-1:2], 2'b00};
    assign bus.out_data  = (state == SEND) ? wbuf[{ptr[1:0], 3'b000} +: 8] : 8'h00;
    assign bus.out_valid = (state == SEND);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
endmodule
